// File: rtl/tt_sweep_pkg.sv
// Shared types and helpers for the truth-table sweep reader.
package tt_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int SETTLE_W = 8;

  function automatic int tt_width(input int n);
    return 1 << n;
  endfunction

endpackage

// File: rtl/tt_settle_counter.sv
// Per-vector hold counter: reloads on load, counts down while enabled, flags the final hold cycle.
module tt_settle_counter
  import tt_sweep_pkg::*;
#(
  parameter int LOAD_VAL = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic last
);

  localparam logic [SETTLE_W-1:0] RELOAD = SETTLE_W'(LOAD_VAL);

  logic [SETTLE_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= RELOAD;
    end else if (en && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign last = (cnt == '0);

endmodule

// File: rtl/tt_sweep_capture.sv
// Sweeps all input vectors of a combinational netlist, shifts its output into a
// library-order truth-table word and reports it against a reference over valid/ready.
module tt_sweep_capture
  import tt_sweep_pkg::*;
#(
  parameter int N_IN   = 4,
  parameter int SETTLE = 2,
  localparam int TT_W  = tt_width(N_IN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [TT_W-1:0] expected,
  output logic [N_IN-1:0] dut_in,
  input  logic            dut_out,
  output logic            busy,
  output logic            result_valid,
  input  logic            result_ready,
  output logic [TT_W-1:0] tt_word,
  output logic            match,
  output logic [N_IN:0]   err_count
);

  localparam logic [N_IN-1:0] LAST_IDX = '1;

  state_t          state;
  state_t          state_next;
  logic            accept;
  logic            sample;
  logic            settle_last;
  logic [TT_W-1:0] exp_q;
  logic [TT_W-1:0] shift_next;
  logic [TT_W-1:0] diff;
  logic [N_IN:0]   pop_next;

  function automatic logic [N_IN:0] popcount(input logic [TT_W-1:0] v);
    logic [N_IN:0] c;
    c = '0;
    for (int k = 0; k < TT_W; k++) begin
      c = c + {{N_IN{1'b0}}, v[k]};
    end
    return c;
  endfunction

  tt_settle_counter #(
    .LOAD_VAL(SETTLE)
  ) u_settle (
    .clk (clk),
    .rst (rst),
    .load(accept | sample),
    .en  (state == DRIVE),
    .last(settle_last)
  );

  // f(0) enters first and ends up at the MSB after TT_W shifts.
  assign shift_next = {tt_word[TT_W-2:0], dut_out};
  assign diff       = shift_next ^ exp_q;
  assign pop_next   = popcount(diff);

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    sample     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = DRIVE;
        end
      end
      DRIVE: begin
        if (settle_last) begin
          sample = 1'b1;
          if (dut_in == LAST_IDX) state_next = DONE;
        end
      end
      DONE: begin
        if (result_ready) begin
          if (start) begin
            accept     = 1'b1;
            state_next = DRIVE;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Control stage: state plus registered status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      busy         <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      state        <= state_next;
      busy         <= (state_next == DRIVE);
      result_valid <= (state_next == DONE);
    end
  end

  // Capture stage: vector index, shift register and final compare.
  always_ff @(posedge clk) begin
    if (rst) begin
      dut_in    <= '0;
      tt_word   <= '0;
      exp_q     <= '0;
      match     <= 1'b0;
      err_count <= '0;
    end else if (accept) begin
      dut_in    <= '0;
      tt_word   <= '0;
      exp_q     <= expected;
      match     <= 1'b0;
      err_count <= '0;
    end else if (sample) begin
      tt_word <= shift_next;
      if (dut_in == LAST_IDX) begin
        match     <= (diff == '0);
        err_count <= pop_next;
      end else begin
        dut_in <= dut_in + 1'b1;
      end
    end
  end

endmodule
